// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file write-port controller.
// Round-robin pick and one-hot decode are sized for up to 8 ports / 8-bit ids.
package regfile_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 16;
   localparam int MAX_ADDR_W = 8;
   localparam int MAX_PORTS  = 8;
   localparam int PIDX_W     = 3;

   typedef struct packed {
      logic              found;
      logic [PIDX_W-1:0] idx;
   } pick_t;

   function automatic logic [2**MAX_ADDR_W-1:0] onehot_of(input logic [MAX_ADDR_W-1:0] id);
      logic [2**MAX_ADDR_W-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // First valid port at or after ptr, wrapping modulo n (n >= 1).
   function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] valid,
                                     input logic [PIDX_W-1:0]    ptr,
                                     input int unsigned          n);
      pick_t       p;
      int unsigned c;
      p = '0;
      for (int unsigned k = 0; k < MAX_PORTS; k++) begin
         c = (32'(ptr) + k) % n;
         if (k < n && !p.found && valid[c[PIDX_W-1:0]]) begin
            p.found = 1'b1;
            p.idx   = c[PIDX_W-1:0];
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the internal pointer.
// Latency: grant is combinational from valid and pointer; pointer moves on advance.
// Backpressure: ungranted requesters simply see grant low; no grant while rst is high.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  valid,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic [IW-1:0]        ptr;
   logic [MAX_PORTS-1:0] vpad;
   pick_t                pick;

   always_comb begin
      vpad         = '0;
      vpad[N-1:0]  = valid;
      pick         = rr_pick(vpad, PIDX_W'(ptr), N);
      idx          = pick.idx[IW-1:0];
      grant        = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = pick.found && !rst && (pick.idx == PIDX_W'(i));
      end
   end

   // Pointer moves just past the port that transferred, so it becomes lowest priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (32'(idx) == N - 1) ? '0 : idx + IW'(1);
      end
   end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write port: round-robin over NUM_PORTS requesters, registered one-hot wordline.
// Latency: a write transferred in cycle N drives wordline/wdata/wport in cycle N+1 for one cycle.
// Backpressure: one wr_ready per cycle; losers hold their request and bump the stall counter.
module regfile_write_ctrl
   import regfile_pkg::*;
#(
   parameter  int ADDR_W       = ADDR_W_DEF,
   parameter  int DATA_W       = DATA_W_DEF,
   parameter  int NUM_PORTS    = 2,
   parameter  int ZERO_PROTECT = 1,
   parameter  int STALL_CNT_W  = 8,
   localparam int WL_W         = 2**ADDR_W,
   localparam int PW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        wr_valid,
   input  logic [NUM_PORTS*ADDR_W-1:0] wr_regid,
   input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
   output logic [NUM_PORTS-1:0]        wr_ready,
   output logic [WL_W-1:0]             wordline,
   output logic [DATA_W-1:0]           wdata,
   output logic [PW-1:0]               wport,
   output logic [STALL_CNT_W-1:0]      stall_cnt
);

   logic [PW-1:0]     gidx;
   logic              xfer;
   logic              stall;
   logic [ADDR_W-1:0] sel_id;
   logic [DATA_W-1:0] sel_data;
   logic [WL_W-1:0]   dec_wl;
   logic              zero_hit;

   rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   (wr_valid),
      .advance (xfer),
      .grant   (wr_ready),
      .idx     (gidx)
   );

   assign xfer  = |(wr_valid & wr_ready);
   assign stall = |(wr_valid & ~wr_ready);

   always_comb begin
      sel_id   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gidx == PW'(i)) begin
            sel_id   = wr_regid[i*ADDR_W +: ADDR_W];
            sel_data = wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign dec_wl   = WL_W'(onehot_of(MAX_ADDR_W'(sel_id)));
   assign zero_hit = (ZERO_PROTECT != 0) && (sel_id == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wordline  <= '0;
         wdata     <= '0;
         wport     <= '0;
         stall_cnt <= '0;
      end else begin
         wordline <= '0;
         if (xfer) begin
            // Register 0 writes still complete the handshake but never touch the array.
            if (!zero_hit) wordline <= dec_wl;
            wdata <= sel_data;
            wport <= gidx;
         end
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench: two configurations driven side by side against a queue-free behavioural model.
module tb_regfile_write_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // Instance a: ADDR_W=4, 2 ports, register 0 protected, 8-bit stall counter.
   logic [1:0]  va;
   logic [7:0]  ra;
   logic [31:0] da;
   logic [1:0]  rdy_a;
   logic [15:0] wl_a;
   logic [15:0] wd_a;
   logic [0:0]  wp_a;
   logic [7:0]  sc_a;

   // Instance b: ADDR_W=5, 3 ports, register 0 writable, 2-bit stall counter.
   logic [2:0]  vb;
   logic [14:0] rb;
   logic [47:0] db;
   logic [2:0]  rdy_b;
   logic [31:0] wl_b;
   logic [15:0] wd_b;
   logic [1:0]  wp_b;
   logic [1:0]  sc_b;

   regfile_write_ctrl #(.ADDR_W(4), .DATA_W(16), .NUM_PORTS(2), .ZERO_PROTECT(1), .STALL_CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .wr_valid(va), .wr_regid(ra), .wr_data(da), .wr_ready(rdy_a),
      .wordline(wl_a), .wdata(wd_a), .wport(wp_a), .stall_cnt(sc_a));

   regfile_write_ctrl #(.ADDR_W(5), .DATA_W(16), .NUM_PORTS(3), .ZERO_PROTECT(0), .STALL_CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .wr_valid(vb), .wr_regid(rb), .wr_data(db), .wr_ready(rdy_b),
      .wordline(wl_b), .wdata(wd_b), .wport(wp_b), .stall_cnt(sc_b));

   int n_checks = 0;
   int n_errors = 0;

   bit          req_v  [2][3];
   logic [7:0]  req_id [2][3];
   logic [15:0] req_d  [2][3];
   int          ptr_m  [2];
   int          last_g [2];
   logic [63:0] e_wl [2];
   logic [63:0] e_wd [2];
   logic [63:0] e_wp [2];
   logic [63:0] e_sc [2];

   function automatic int np(int i);   return (i == 0) ? 2 : 3; endfunction
   function automatic int aw(int i);   return (i == 0) ? 4 : 5; endfunction
   function automatic bit zp(int i);   return (i == 0); endfunction
   function automatic int smax(int i); return (i == 0) ? 255 : 3; endfunction

   function automatic logic [63:0] got_rdy(int i); return (i == 0) ? 64'(rdy_a) : 64'(rdy_b); endfunction
   function automatic logic [63:0] got_wl(int i);  return (i == 0) ? 64'(wl_a)  : 64'(wl_b);  endfunction
   function automatic logic [63:0] got_wd(int i);  return (i == 0) ? 64'(wd_a)  : 64'(wd_b);  endfunction
   function automatic logic [63:0] got_wp(int i);  return (i == 0) ? 64'(wp_a)  : 64'(wp_b);  endfunction
   function automatic logic [63:0] got_sc(int i);  return (i == 0) ? 64'(sc_a)  : 64'(sc_b);  endfunction

   function automatic string tg(string name, int i);
      return $sformatf("%s_%s", name, (i == 0) ? "a" : "b");
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input int p, input int id, input logic [15:0] d);
      req_v[i][p]  = 1'b1;
      req_id[i][p] = 8'(id);
      req_d[i][p]  = d;
   endtask

   task automatic drive();
      va = '0; ra = '0; da = '0; vb = '0; rb = '0; db = '0;
      for (int p = 0; p < 2; p++) begin
         va[p]        = req_v[0][p];
         ra[p*4 +: 4] = req_id[0][p][3:0];
         da[p*16 +: 16] = req_d[0][p];
      end
      for (int p = 0; p < 3; p++) begin
         vb[p]        = req_v[1][p];
         rb[p*5 +: 5] = req_id[1][p][4:0];
         db[p*16 +: 16] = req_d[1][p];
      end
   endtask

   // One clock: check grants mid-cycle, advance the model, check registered outputs after the edge.
   task automatic step();
      int          g;
      int          nv;
      int          p;
      logic [63:0] exp_rdy;
      drive();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         g  = -1;
         nv = 0;
         for (int k = 0; k < np(i); k++) begin
            p = (ptr_m[i] + k) % np(i);
            if (req_v[i][k]) nv++;
            if (!rst && g < 0 && req_v[i][p]) g = p;
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         check(tg("wr_ready", i), got_rdy(i), exp_rdy);
         if (rst) begin
            ptr_m[i] = 0; e_wl[i] = '0; e_wd[i] = '0; e_wp[i] = '0; e_sc[i] = '0;
         end else begin
            if (g >= 0) begin
               e_wl[i]  = (zp(i) && req_id[i][g] == 0) ? 64'd0 : (64'd1 << req_id[i][g]);
               e_wd[i]  = 64'(req_d[i][g]);
               e_wp[i]  = 64'(g);
               ptr_m[i] = (g + 1) % np(i);
            end else begin
               e_wl[i] = '0;
            end
            if (nv > ((g >= 0) ? 1 : 0) && e_sc[i] < 64'(smax(i))) e_sc[i] = e_sc[i] + 1;
         end
         last_g[i] = g;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check(tg("wordline", i),  got_wl(i), e_wl[i]);
         check(tg("wdata", i),     got_wd(i), e_wd[i]);
         check(tg("wport", i),     got_wp(i), e_wp[i]);
         check(tg("stall_cnt", i), got_sc(i), e_sc[i]);
         if (last_g[i] >= 0) req_v[i][last_g[i]] = 1'b0;
      end
   endtask

   logic [15:0] cont_wl [3] = '{16'h0008, 16'h0200, 16'h0008};

   initial begin
      for (int i = 0; i < 2; i++) begin
         ptr_m[i] = 0; last_g[i] = -1;
         e_wl[i] = '0; e_wd[i] = '0; e_wp[i] = '0; e_sc[i] = '0;
         for (int p = 0; p < 3; p++) begin
            req_v[i][p] = 1'b0; req_id[i][p] = '0; req_d[i][p] = '0;
         end
      end

      // Reset held with both ports of a requesting.
      rst = 1'b1;
      set_req(0, 0, 3, 16'h1111);
      set_req(0, 1, 9, 16'h2222);
      step();
      step();
      check("rst_wordline", 64'(wl_a), 64'd0);
      check("rst_stall", 64'(sc_a), 64'd0);
      rst = 1'b0;

      // Continuous contention: grants alternate starting at port 0.
      for (int c = 0; c < 3; c++) begin
         step();
         check("cont_wordline", 64'(wl_a), 64'(cont_wl[c]));
         check("cont_stall", 64'(sc_a), 64'(c + 1));
         if (!req_v[0][0]) set_req(0, 0, 3, 16'h1111);
         if (!req_v[0][1]) set_req(0, 1, 9, 16'h2222);
      end
      req_v[0][0] = 1'b0;
      req_v[0][1] = 1'b0;

      // Single write then idle.
      set_req(0, 0, 5, 16'hBEEF);
      step();
      check("single_wordline", 64'(wl_a), 64'h0020);
      check("single_wdata", 64'(wd_a), 64'hBEEF);
      check("single_wport", 64'(wp_a), 64'd0);
      step();
      check("idle_wordline", 64'(wl_a), 64'd0);

      // Register 0: protected on a, writable on b.
      set_req(0, 0, 0, 16'h1234);
      set_req(1, 0, 0, 16'h1234);
      step();
      check("zp_wordline_a", 64'(wl_a), 64'd0);
      check("zp_wdata_a", 64'(wd_a), 64'h1234);
      check("nozp_wordline_b", 64'(wl_b), 64'd1);

      // Sweep every id on b from rotating ports.
      for (int id = 0; id < 32; id++) begin
         set_req(1, id % 3, id, 16'($urandom));
         step();
         check("sweep_onehot", 64'($countones(wl_b)), 64'd1);
         check("sweep_wordline", 64'(wl_b), 64'd1 << id);
         check("sweep_wport", 64'(wp_b), 64'(id % 3));
      end

      // Saturation of the 2-bit stall counter under 3-way contention.
      for (int c = 0; c < 5; c++) begin
         for (int p = 0; p < 3; p++) if (!req_v[1][p]) set_req(1, p, 4 + p, 16'($urandom));
         step();
      end
      check("sat_stall", 64'(sc_b), 64'd3);

      // Reset asserted while requests are pending.
      for (int p = 0; p < 3; p++) if (!req_v[1][p]) set_req(1, p, 7, 16'h5A5A);
      rst = 1'b1;
      step();
      check("midrst_wordline", 64'(wl_b), 64'd0);
      check("midrst_stall", 64'(sc_b), 64'd0);
      rst = 1'b0;

      // Random traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < np(i); p++) begin
               if (!req_v[i][p] && $urandom_range(0, 2) == 0)
                  set_req(i, p, int'($urandom_range(0, (1 << aw(i)) - 1)), 16'($urandom));
            end
         end
         rst = ($urandom_range(0, 39) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
